id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32 core; sits directly upstream of the EX-stage forwarding unit and ALU.
- Captures decoded control, register-file read data, immediate, function bits and register addresses from ID each cycle.
- Supports a memory-stall hold (data-cache miss freezes the pipeline) and flush-to-bubble (load-use hazard or branch), with a flush that arrives during a stall held pending until the stall releases.
- Keeps saturating bubble and stall counters for performance debug.

Parameters:
- DATA_W, 32, width of the RS1/RS2 data and immediate fields
- CNT_W, 16, width of each performance counter

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  asynchronous reset, active-low: asserting low clears all state immediately
- stall_i  in  1  memory stall; when 1, hold all captured fields
- flush_i  in  1  request to load a bubble instead of the ID contents
- ID_RegWrite_i / ID_MemtoReg_i / ID_MemRead_i / ID_MemWrite_i / ID_ALUSrc_i  in  1 each  control bits
- ID_ALUOp_i  in  2  ALU op class
- ID_RS1data_i / ID_RS2data_i / ID_Imm_i  in  DATA_W each  operands
- ID_funct_i  in  10  {funct7, funct3}
- ID_RS1_i / ID_RS2_i / ID_Rd_i  in  5 each  register addresses
- EX_* outputs  out  same widths  registered copies of every ID_* input above
- EX_RS1_o / EX_RS2_o  out  5 each  registered copies of ID_RS1_i / ID_RS2_i; these drive the forwarding unit's source-address inputs
- EX_valid_o  out  1  1 = real instruction in EX; 0 = bubble
- flush_pending_o  out  1  a flush is latched and waiting for the stall to clear
- bubble_cnt_o / stall_cnt_o  out  CNT_W each  performance counters

Behaviour:
- Reset (rst_i=0, async): every output is 0, flush_pending_o is 0, and both counters are 0. EX_valid_o=0 means the pipe starts holding a bubble.
- Define eff_flush = flush_i | flush_pending. Per rising edge, in priority order:
  - stall_i=1:
    - All EX_* fields and EX_valid_o hold.
    - If flush_i=1, flush_pending is set to 1; flush_pending never clears while stalled.
    - stall_cnt increments.
  - stall_i=0 and eff_flush=1:
    - Load a bubble: all control outputs 0, data/imm/funct 0, RS1/RS2/Rd 0, EX_valid_o=0.
    - flush_pending clears.
    - bubble_cnt increments.
  - Otherwise: capture all ID_* inputs and set EX_valid_o=1.
- Zeroed RS1/RS2/Rd in a bubble guarantee the forwarding unit's x0 check never matches a bubble.
- Latency: exactly 1 cycle from ID_* inputs to EX_* outputs when not stalled and not flushed.
- Counters saturate at all-ones, with no wrap; each counter increments at most once per edge.
- Simultaneous stall_i and flush_i: the stall wins and the flush is deferred. The bubble loads on the first edge with stall_i=0, regardless of flush_i on that edge.
- Back-to-back flush with no stall: a bubble loads each cycle.
- Reset asserted mid-stall with a flush pending: the pending flag is lost, which is intended, since reset already leaves a bubble.
- There is no combinational path from inputs to outputs; all outputs come straight from flops.

Test Plan:
- Reset release, then ID_RS1_i=5, ID_Rd_i=7, ID_RegWrite_i=1, ID_RS1data_i=0x1234, no stall or flush -> after one edge EX_RS1_o=5, EX_Rd_o=7, EX_RegWrite_o=1, EX_RS1data_o=0x1234, EX_valid_o=1.
- Instruction captured, then stall_i=1 for 3 edges while the ID inputs change -> EX outputs unchanged for all 3 edges; stall_cnt_o=3; bubble_cnt_o=0.
- flush_i=1 for one edge with no stall -> next edge all EX outputs 0, EX_valid_o=0, bubble_cnt_o=1; the following edge with flush_i=0 captures ID normally.
- stall_i=1 with a one-cycle flush_i pulse in cycle 2 of a 4-cycle stall -> flush_pending_o=1 from that edge on and EX fields hold. On the first edge with stall_i=0 a bubble loads, flush_pending_o=0, bubble_cnt_o=1.
- With CNT_W=4, hold stall_i=1 for 20 edges -> stall_cnt_o reaches 15 and stays there.
- Assert rst_i=0 asynchronously mid-clock with flush_pending_o=1 and valid data in EX -> all outputs 0 immediately, without waiting for a clock edge; after release the first unstalled edge captures ID.

Source files
------------

// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if: ID-side fields into, and EX-side registered copies out of, the ID/EX pipeline register
//   ID_* : decoded control, operands, funct and register addresses from ID
//   EX_* : registered copies of ID_*, plus EX_valid_o (0 = bubble)
//   flush_pending_o : a flush is latched and waiting for the stall to clear
//   bubble_cnt_o / stall_cnt_o : saturating performance counters
interface id_ex_pipe_if #(parameter int DATA_W = 32, parameter int CNT_W = 16);
  logic ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i, ID_MemWrite_i, ID_ALUSrc_i;
  logic [1:0] ID_ALUOp_i;
  logic [DATA_W-1:0] ID_RS1data_i, ID_RS2data_i, ID_Imm_i;
  logic [9:0] ID_funct_i;
  logic [4:0] ID_RS1_i, ID_RS2_i, ID_Rd_i;
  logic EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o;
  logic [1:0] EX_ALUOp_o;
  logic [DATA_W-1:0] EX_RS1data_o, EX_RS2data_o, EX_Imm_o;
  logic [9:0] EX_funct_o;
  logic [4:0] EX_RS1_o, EX_RS2_o, EX_Rd_o;
  logic EX_valid_o, flush_pending_o;
  logic [CNT_W-1:0] bubble_cnt_o, stall_cnt_o;
  modport master (
    output ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i, ID_MemWrite_i, ID_ALUSrc_i, ID_ALUOp_i,
           ID_RS1data_i, ID_RS2data_i, ID_Imm_i, ID_funct_i, ID_RS1_i, ID_RS2_i, ID_Rd_i,
    input  EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o, EX_ALUOp_o,
           EX_RS1data_o, EX_RS2data_o, EX_Imm_o, EX_funct_o, EX_RS1_o, EX_RS2_o, EX_Rd_o,
           EX_valid_o, flush_pending_o, bubble_cnt_o, stall_cnt_o
  );
  modport slave (
    input  ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i, ID_MemWrite_i, ID_ALUSrc_i, ID_ALUOp_i,
           ID_RS1data_i, ID_RS2data_i, ID_Imm_i, ID_funct_i, ID_RS1_i, ID_RS2_i, ID_Rd_i,
    output EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o, EX_ALUOp_o,
           EX_RS1data_o, EX_RS2data_o, EX_Imm_o, EX_funct_o, EX_RS1_o, EX_RS2_o, EX_Rd_o,
           EX_valid_o, flush_pending_o, bubble_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall hold, deferred flush-to-bubble and saturating counters
//   clk_i   : core clock, rising edge
//   rst_i   : asynchronous active-low reset, leaves a bubble in EX
//   stall_i : hold all EX fields
//   flush_i : load a bubble (deferred while stalled)
//   bus     : slave side of id_ex_pipe_if (ID_* in, EX_*/status/counters out)
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  input  logic flush_i,
  id_ex_pipe_if.slave bus
);
  localparam int BW = 3 * DATA_W + 32;
  logic [BW-1:0] idFields, exFields;
  logic exValid, flushPending;
  logic [CNT_W-1:0] bubbleCnt, stallCnt;
  assign idFields = {bus.ID_RegWrite_i, bus.ID_MemtoReg_i, bus.ID_MemRead_i, bus.ID_MemWrite_i,
                     bus.ID_ALUSrc_i, bus.ID_ALUOp_i, bus.ID_RS1data_i, bus.ID_RS2data_i,
                     bus.ID_Imm_i, bus.ID_funct_i, bus.ID_RS1_i, bus.ID_RS2_i, bus.ID_Rd_i};
  // A bubble is all-zero, so RS1/RS2/Rd of 0 never match the forwarding unit's x0-gated compare
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      exFields <= '0;
      exValid <= 1'b0;
      flushPending <= 1'b0;
      bubbleCnt <= '0;
      stallCnt <= '0;
    end else if (stall_i) begin
      flushPending <= flushPending | flush_i;
      stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, ~&stallCnt};
    end else if (flush_i | flushPending) begin
      exFields <= '0;
      exValid <= 1'b0;
      flushPending <= 1'b0;
      bubbleCnt <= bubbleCnt + {{(CNT_W-1){1'b0}}, ~&bubbleCnt};
    end else begin
      exFields <= idFields;
      exValid <= 1'b1;
    end
  assign {bus.EX_RegWrite_o, bus.EX_MemtoReg_o, bus.EX_MemRead_o, bus.EX_MemWrite_o,
          bus.EX_ALUSrc_o, bus.EX_ALUOp_o, bus.EX_RS1data_o, bus.EX_RS2data_o,
          bus.EX_Imm_o, bus.EX_funct_o, bus.EX_RS1_o, bus.EX_RS2_o, bus.EX_Rd_o} = exFields;
  assign bus.EX_valid_o = exValid;
  assign bus.flush_pending_o = flushPending;
  assign bus.bubble_cnt_o = bubbleCnt;
  assign bus.stall_cnt_o = stallCnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: self-checking bench for id_ex_pipe_reg (main DUT CNT_W=16, second DUT CNT_W=4 for saturation)
module tb_id_ex_pipe_reg;
  typedef struct packed {
    logic regWrite, memtoReg, memRead, memWrite, aluSrc;
    logic [1:0] aluOp;
    logic [31:0] rs1Data, rs2Data, imm;
    logic [9:0] funct;
    logic [4:0] rs1, rs2, rd;
    logic valid;
  } fields_t;
  logic clk_i = 1'b0, rst_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  int checks = 0, failures = 0;
  fields_t expEx;
  logic expPend;
  int expBub, expStall;
  fields_t sbQ[$];
  always #5 clk_i = ~clk_i;
  id_ex_pipe_if #(.DATA_W(32), .CNT_W(16)) bus ();
  id_ex_pipe_if #(.DATA_W(32), .CNT_W(4)) busS ();
  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(16)) dut (.clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .bus(bus));
  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(4)) dutS (.clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .bus(busS));
  task automatic drive(input fields_t x);
    {bus.ID_RegWrite_i, bus.ID_MemtoReg_i, bus.ID_MemRead_i, bus.ID_MemWrite_i, bus.ID_ALUSrc_i} =
      {x.regWrite, x.memtoReg, x.memRead, x.memWrite, x.aluSrc};
    {bus.ID_ALUOp_i, bus.ID_RS1data_i, bus.ID_RS2data_i, bus.ID_Imm_i} = {x.aluOp, x.rs1Data, x.rs2Data, x.imm};
    {bus.ID_funct_i, bus.ID_RS1_i, bus.ID_RS2_i, bus.ID_Rd_i} = {x.funct, x.rs1, x.rs2, x.rd};
    {busS.ID_RegWrite_i, busS.ID_MemtoReg_i, busS.ID_MemRead_i, busS.ID_MemWrite_i, busS.ID_ALUSrc_i} =
      {x.regWrite, x.memtoReg, x.memRead, x.memWrite, x.aluSrc};
    {busS.ID_ALUOp_i, busS.ID_RS1data_i, busS.ID_RS2data_i, busS.ID_Imm_i} = {x.aluOp, x.rs1Data, x.rs2Data, x.imm};
    {busS.ID_funct_i, busS.ID_RS1_i, busS.ID_RS2_i, busS.ID_Rd_i} = {x.funct, x.rs1, x.rs2, x.rd};
  endtask
  function automatic fields_t sample();
    fields_t g;
    g = {bus.EX_RegWrite_o, bus.EX_MemtoReg_o, bus.EX_MemRead_o, bus.EX_MemWrite_o, bus.EX_ALUSrc_o,
         bus.EX_ALUOp_o, bus.EX_RS1data_o, bus.EX_RS2data_o, bus.EX_Imm_o, bus.EX_funct_o,
         bus.EX_RS1_o, bus.EX_RS2_o, bus.EX_Rd_o, bus.EX_valid_o};
    return g;
  endfunction
  function automatic fields_t rnd();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[128:0];
  endfunction
  task automatic clear_model();
    expEx = '0;
    expPend = 1'b0;
    expBub = 0;
    expStall = 0;
  endtask
  // One edge: compute expectation, push to scoreboard, clock, pop and compare everything
  task automatic step(input logic s, input logic f, input fields_t id);
    fields_t e, g;
    int satS;
    stall_i = s;
    flush_i = f;
    drive(id);
    if (s) begin
      expPend = expPend | f;
      expStall++;
    end else if (f || expPend) begin
      expEx = '0;
      expPend = 1'b0;
      expBub++;
    end else begin
      expEx = id;
      expEx.valid = 1'b1;
    end
    sbQ.push_back(expEx);
    @(posedge clk_i);
    #1;
    e = sbQ.pop_front();
    g = sample();
    satS = expStall > 15 ? 15 : expStall;
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL ex_fields got=%h exp=%h", g, e);
    end
    checks++;
    if (bus.flush_pending_o !== expPend) begin
      failures++;
      $display("FAIL flush_pending got=%b exp=%b", bus.flush_pending_o, expPend);
    end
    checks++;
    if (bus.bubble_cnt_o !== 16'(expBub) || bus.stall_cnt_o !== 16'(expStall)) begin
      failures++;
      $display("FAIL counters got=%0d/%0d exp=%0d/%0d", bus.bubble_cnt_o, bus.stall_cnt_o, expBub, expStall);
    end
    checks++;
    if (busS.stall_cnt_o !== 4'(satS)) begin
      failures++;
      $display("FAIL sat_stall_cnt got=%0d exp=%0d", busS.stall_cnt_o, satS);
    end
  endtask
  task automatic do_reset();
    #2;
    rst_i = 1'b0;
    #1;
    clear_model();
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask
  task automatic test_reset();
    fields_t g;
    rst_i = 1'b0;
    clear_model();
    drive(rnd());
    repeat (2) @(posedge clk_i);
    #1;
    g = sample();
    checks++;
    if (g !== '0 || bus.flush_pending_o !== 1'b0 || bus.bubble_cnt_o !== 16'd0 || bus.stall_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got=%h pend=%b", g, bus.flush_pending_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask
  task automatic test_capture();
    fields_t x;
    x = '0;
    x.rs1 = 5'd5;
    x.rd = 5'd7;
    x.regWrite = 1'b1;
    x.rs1Data = 32'h1234;
    step(1'b0, 1'b0, x);
    checks++;
    if (bus.EX_RS1_o !== 5'd5 || bus.EX_Rd_o !== 5'd7 || bus.EX_RegWrite_o !== 1'b1 ||
        bus.EX_RS1data_o !== 32'h1234 || bus.EX_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL capture got rs1=%0d rd=%0d rw=%b d=%h v=%b exp 5 7 1 1234 1",
               bus.EX_RS1_o, bus.EX_Rd_o, bus.EX_RegWrite_o, bus.EX_RS1data_o, bus.EX_valid_o);
    end
    repeat (3) step(1'b0, 1'b0, rnd());
  endtask
  task automatic test_stall();
    fields_t held;
    step(1'b0, 1'b0, rnd());
    held = sample();
    repeat (3) step(1'b1, 1'b0, rnd());
    checks++;
    if (sample() !== held || bus.stall_cnt_o !== 16'd3 || bus.bubble_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL stall_hold got=%h stall=%0d bub=%0d exp=%h 3 0", sample(), bus.stall_cnt_o, bus.bubble_cnt_o, held);
    end
  endtask
  task automatic test_flush();
    step(1'b0, 1'b0, rnd());
    step(1'b0, 1'b1, rnd());
    checks++;
    if (sample() !== '0 || bus.bubble_cnt_o !== 16'd1) begin
      failures++;
      $display("FAIL flush_bubble got=%h bub=%0d exp=0 1", sample(), bus.bubble_cnt_o);
    end
    step(1'b0, 1'b0, rnd());
    repeat (3) step(1'b0, 1'b1, rnd());
    step(1'b0, 1'b0, rnd());
  endtask
  task automatic test_deferred_flush();
    fields_t held;
    step(1'b0, 1'b0, rnd());
    held = sample();
    step(1'b1, 1'b0, rnd());
    step(1'b1, 1'b1, rnd());
    step(1'b1, 1'b0, rnd());
    step(1'b1, 1'b0, rnd());
    checks++;
    if (bus.flush_pending_o !== 1'b1 || sample() !== held) begin
      failures++;
      $display("FAIL deferred_pending got=%b exp=1", bus.flush_pending_o);
    end
    step(1'b0, 1'b0, rnd());
    checks++;
    if (bus.flush_pending_o !== 1'b0 || bus.EX_valid_o !== 1'b0 || bus.bubble_cnt_o !== 16'd1) begin
      failures++;
      $display("FAIL deferred_bubble got pend=%b v=%b bub=%0d exp 0 0 1", bus.flush_pending_o, bus.EX_valid_o, bus.bubble_cnt_o);
    end
    step(1'b0, 1'b0, rnd());
  endtask
  task automatic test_saturation();
    repeat (20) step(1'b1, 1'b0, rnd());
    checks++;
    if (busS.stall_cnt_o !== 4'hF || bus.stall_cnt_o !== 16'd20) begin
      failures++;
      $display("FAIL saturation got=%0d/%0d exp=15/20", busS.stall_cnt_o, bus.stall_cnt_o);
    end
    step(1'b0, 1'b0, rnd());
  endtask
  task automatic test_async_reset();
    step(1'b0, 1'b0, rnd());
    step(1'b1, 1'b1, rnd());
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (sample() !== '0 || bus.flush_pending_o !== 1'b0 || bus.stall_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL async_reset got=%h pend=%b stall=%0d exp 0", sample(), bus.flush_pending_o, bus.stall_cnt_o);
    end
    clear_model();
    rst_i = 1'b1;
    @(negedge clk_i);
    step(1'b0, 1'b0, rnd());
    checks++;
    if (bus.EX_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_capture got=%b exp=1", bus.EX_valid_o);
    end
  endtask
  initial begin
    test_reset();
    test_capture();
    do_reset();
    test_stall();
    do_reset();
    test_flush();
    do_reset();
    test_deferred_flush();
    do_reset();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
